// File: rtl/calendar_counter.sv
// Calendar date counter: day/month/year with Gregorian leap years,
// preset load with legality check, and registered carry/error pulses.
module calendar_counter #(
   parameter int YEAR_W   = 12,
   parameter int YEAR_MIN = 2000,
   parameter int YEAR_MAX = 2399,
   parameter bit WRAP     = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              day_tick,
   input  logic              load,
   input  logic [4:0]        set_day,
   input  logic [3:0]        set_month,
   input  logic [YEAR_W-1:0] set_year,
   output logic [4:0]        day,
   output logic [3:0]        month,
   output logic [YEAR_W-1:0] year,
   output logic              month_carry,
   output logic              year_carry,
   output logic              load_err
);

   localparam logic [YEAR_W-1:0] Y_MIN = YEAR_W'(YEAR_MIN);
   localparam logic [YEAR_W-1:0] Y_MAX = YEAR_W'(YEAR_MAX);
   localparam logic [YEAR_W-1:0] Y_ONE = YEAR_W'(1);

   // Gregorian leap rule on the full binary year value.
   function automatic logic is_leap(input logic [YEAR_W-1:0] y);
      int unsigned v;
      v = 32'(y);
      return ((v % 4 == 0) && (v % 100 != 0)) || (v % 400 == 0);
   endfunction

   // Length of month m in year y; months outside 1..12 are screened elsewhere.
   function automatic logic [4:0] days_in(input logic [3:0] m,
                                          input logic [YEAR_W-1:0] y);
      logic [4:0] d;
      case (m)
         4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
         4'd2:                    d = is_leap(y) ? 5'd29 : 5'd28;
         default:                 d = 5'd31;
      endcase
      return d;
   endfunction

   logic [4:0] cur_days;
   logic [4:0] set_days;
   logic       load_ok;
   logic       last_day;
   logic       at_year_max;

   assign cur_days    = days_in(month, year);
   assign set_days    = days_in(set_month, set_year);
   assign last_day    = (day >= cur_days);
   assign at_year_max = (year >= Y_MAX);

   assign load_ok = (set_month >= 4'd1) && (set_month <= 4'd12) &&
                    (set_year >= Y_MIN) && (set_year <= Y_MAX) &&
                    (set_day >= 5'd1) && (set_day <= set_days);

   // Date register and one-cycle status pulses; load wins over day_tick.
   // NOTE: every register here uses <= so all branches see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         day         <= 5'd1;
         month       <= 4'd1;
         year        <= Y_MIN;
         month_carry <= 1'b0;
         year_carry  <= 1'b0;
         load_err    <= 1'b0;
      end else begin
         // NOTE: pulses default low each cycle so they last exactly one cycle.
         month_carry <= 1'b0;
         year_carry  <= 1'b0;
         load_err    <= 1'b0;
         if (en) begin
            if (load) begin
               if (load_ok) begin
                  day   <= set_day;
                  month <= set_month;
                  year  <= set_year;
               end else begin
                  load_err <= 1'b1;
               end
            end else if (day_tick) begin
               if (!last_day) begin
                  day <= day + 5'd1;
               end else if (month != 4'd12) begin
                  day         <= 5'd1;
                  month       <= month + 4'd1;
                  month_carry <= 1'b1;
               end else if (!at_year_max) begin
                  day         <= 5'd1;
                  month       <= 4'd1;
                  year        <= year + Y_ONE;
                  month_carry <= 1'b1;
                  year_carry  <= 1'b1;
               end else if (WRAP) begin
                  day         <= 5'd1;
                  month       <= 4'd1;
                  year        <= Y_MIN;
                  month_carry <= 1'b1;
                  year_carry  <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_calendar_counter.sv
// Bench for calendar_counter: a wrapping and a saturating instance share
// stimulus and are compared against a date-arithmetic reference model.
module tb_calendar_counter;

   typedef struct {
      int d;
      int m;
      int y;
      bit mc;
      bit yc;
      bit le;
   } date_t;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        day_tick;
   logic        load;
   logic [4:0]  set_day;
   logic [3:0]  set_month;
   logic [11:0] set_year;

   logic [4:0]  w_day,  s_day;
   logic [3:0]  w_month, s_month;
   logic [11:0] w_year, s_year;
   logic        w_mc, w_yc, w_le, s_mc, s_yc, s_le;

   int n_checks = 0;
   int n_pass   = 0;

   date_t mw;
   date_t ms;

   calendar_counter #(.YEAR_W(12), .YEAR_MIN(2000), .YEAR_MAX(2399), .WRAP(1'b1)) dut_w (
      .clk(clk), .rst_n(rst_n), .en(en), .day_tick(day_tick), .load(load),
      .set_day(set_day), .set_month(set_month), .set_year(set_year),
      .day(w_day), .month(w_month), .year(w_year),
      .month_carry(w_mc), .year_carry(w_yc), .load_err(w_le));

   calendar_counter #(.YEAR_W(12), .YEAR_MIN(2000), .YEAR_MAX(2399), .WRAP(1'b0)) dut_s (
      .clk(clk), .rst_n(rst_n), .en(en), .day_tick(day_tick), .load(load),
      .set_day(set_day), .set_month(set_month), .set_year(set_year),
      .day(s_day), .month(s_month), .year(s_year),
      .month_carry(s_mc), .year_carry(s_yc), .load_err(s_le));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
   endtask

   function automatic int mdays(input int m, input int y);
      int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
      bit leap;
      leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
      if (m == 2 && leap) return 29;
      return tbl[m-1];
   endfunction

   function automatic date_t reset_date();
      date_t r;
      r.d = 1; r.m = 1; r.y = 2000; r.mc = 0; r.yc = 0; r.le = 0;
      return r;
   endfunction

   // Next date/pulses from the calendar rules.
   function automatic date_t mstep(input date_t s, input bit wrap, input bit e,
                                   input bit t, input bit l,
                                   input int sd, input int sm, input int sy);
      date_t n;
      n = s;
      n.mc = 0; n.yc = 0; n.le = 0;
      if (!e) return n;
      if (l) begin
         if (sm >= 1 && sm <= 12 && sy >= 2000 && sy <= 2399 &&
             sd >= 1 && sd <= mdays(sm, sy)) begin
            n.d = sd; n.m = sm; n.y = sy;
         end else begin
            n.le = 1;
         end
      end else if (t) begin
         if (s.d < mdays(s.m, s.y)) begin
            n.d = s.d + 1;
         end else if (s.m < 12) begin
            n.d = 1; n.m = s.m + 1; n.mc = 1;
         end else if (s.y < 2399) begin
            n.d = 1; n.m = 1; n.y = s.y + 1; n.mc = 1; n.yc = 1;
         end else if (wrap) begin
            n.d = 1; n.m = 1; n.y = 2000; n.mc = 1; n.yc = 1;
         end
      end
      return n;
   endfunction

   task automatic compare_all(input string tag);
      check({tag, "/w_day"},   32'(w_day),   mw.d);
      check({tag, "/w_month"}, 32'(w_month), mw.m);
      check({tag, "/w_year"},  32'(w_year),  mw.y);
      check({tag, "/w_mc"},    32'(w_mc),    32'(mw.mc));
      check({tag, "/w_yc"},    32'(w_yc),    32'(mw.yc));
      check({tag, "/w_le"},    32'(w_le),    32'(mw.le));
      check({tag, "/s_day"},   32'(s_day),   ms.d);
      check({tag, "/s_month"}, 32'(s_month), ms.m);
      check({tag, "/s_year"},  32'(s_year),  ms.y);
      check({tag, "/s_mc"},    32'(s_mc),    32'(ms.mc));
      check({tag, "/s_yc"},    32'(s_yc),    32'(ms.yc));
      check({tag, "/s_le"},    32'(s_le),    32'(ms.le));
   endtask

   // Drive one cycle of stimulus, advance the model, check after the edge.
   task automatic cycle(input bit e, input bit t, input bit l,
                        input int sd, input int sm, input int sy, input string tag);
      en = e; day_tick = t; load = l;
      set_day = 5'(sd); set_month = 4'(sm); set_year = 12'(sy);
      mw = mstep(mw, 1'b1, e, t, l, sd, sm, sy);
      ms = mstep(ms, 1'b0, e, t, l, sd, sm, sy);
      @(posedge clk);
      #1;
      compare_all(tag);
   endtask

   task automatic idle(input string tag);
      cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, tag);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; day_tick = 1'b0; load = 1'b0;
      set_day = '0; set_month = '0; set_year = '0;
      mw = reset_date(); ms = reset_date();
      #12;
      compare_all("reset");
      rst_n = 1'b1;

      // First enabled edge after reset operates normally.
      cycle(1, 1, 0, 0, 0, 0, "first_tick");

      // Invalid loads from 5/6/2024.
      cycle(1, 0, 1, 5, 6, 2024, "load_5_6_2024");
      cycle(1, 0, 1, 31, 4, 2024, "bad_31_4");
      idle("bad_31_4_after");
      cycle(1, 0, 1, 29, 2, 2023, "bad_29_2_2023");
      idle("bad_29_2_after");
      cycle(1, 0, 1, 5, 13, 2024, "bad_month13");
      idle("bad_month13_after");
      cycle(1, 0, 1, 5, 6, 1999, "bad_year1999");
      idle("bad_year1999_after");
      cycle(1, 0, 1, 0, 6, 2024, "bad_day0");

      // Leap years.
      cycle(1, 0, 1, 28, 2, 2024, "load_28_2_2024");
      cycle(1, 1, 0, 0, 0, 0, "tick_29_2_2024");
      cycle(1, 1, 0, 0, 0, 0, "tick_1_3_2024");
      idle("after_1_3_2024");
      cycle(1, 0, 1, 28, 2, 2100, "load_28_2_2100");
      cycle(1, 1, 0, 0, 0, 0, "tick_1_3_2100");
      cycle(1, 0, 1, 28, 2, 2000, "load_28_2_2000");
      cycle(1, 1, 0, 0, 0, 0, "tick_29_2_2000");

      // Year rollover.
      cycle(1, 0, 1, 31, 12, 2023, "load_31_12_2023");
      cycle(1, 1, 0, 0, 0, 0, "tick_1_1_2024");
      idle("after_1_1_2024");

      // Priority and enable.
      cycle(1, 1, 1, 10, 10, 2030, "load_over_tick");
      cycle(0, 1, 1, 1, 1, 2001, "en0_tick_load");
      cycle(0, 1, 1, 31, 4, 2001, "en0_bad_load");
      cycle(0, 1, 0, 0, 0, 0, "en0_tick");

      // Range end: wrap instance rolls to 2000, saturating instance holds.
      cycle(1, 0, 1, 31, 12, 2399, "load_31_12_2399");
      cycle(1, 1, 0, 0, 0, 0, "range_end_tick");
      idle("range_end_after");
      cycle(1, 1, 0, 0, 0, 0, "range_end_tick2");

      // Back-to-back ticks across a month boundary.
      cycle(1, 0, 1, 20, 1, 2024, "load_20_1_2024");
      for (int i = 0; i < 45; i++) cycle(1, 1, 0, 0, 0, 0, "b2b_tick");

      // Asynchronous reset mid-count while a carry pulse is high.
      cycle(1, 0, 1, 31, 1, 2025, "load_31_1_2025");
      cycle(1, 1, 0, 0, 0, 0, "tick_carry_pre_rst");
      #1;
      rst_n = 1'b0;
      mw = reset_date(); ms = reset_date();
      #1;
      compare_all("async_rst");
      en = 1'b1; day_tick = 1'b1; load = 1'b1;
      set_day = 5'd9; set_month = 4'd9; set_year = 12'd2099;
      @(posedge clk);
      #1;
      compare_all("rst_hold");
      #2;
      rst_n = 1'b1;
      cycle(1, 1, 0, 0, 0, 0, "post_rst_tick");

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         bit e, t, l;
         int sd, sm, sy;
         e  = ($urandom_range(0, 99) < 90);
         l  = ($urandom_range(0, 19) == 0);
         t  = ($urandom_range(0, 3) != 0);
         sy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2395, 2399))
                                          : int'($urandom_range(1995, 2405));
         sm = ($urandom_range(0, 3) == 0) ? 12 : int'($urandom_range(0, 15));
         sd = ($urandom_range(0, 1) == 0) ? int'($urandom_range(26, 31))
                                          : int'($urandom_range(0, 31));
         cycle(e, t, l, sd, sm, sy, "rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/calendar_counter.md
CALENDAR_COUNTER -- requirements
Module: calendar_counter

Interface
REQ-001 Parameter YEAR_W, default 12, SHALL set the year register width in bits.
REQ-002 Parameter YEAR_MIN, default 2000, SHALL set the lowest legal year and the reset year.
REQ-003 Parameter YEAR_MAX, default 2399, SHALL set the highest legal year; YEAR_MIN < YEAR_MAX < 2**YEAR_W.
REQ-004 Parameter WRAP, default 1, SHALL select rollover past YEAR_MAX: 1 = wrap to YEAR_MIN, 0 = saturate.
REQ-005 Port clk, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-007 Port en, input, 1, SHALL be the counter enable; en=0 freezes the date.
REQ-008 Port day_tick, input, 1, SHALL be a one-cycle strobe requesting advance by one day.
REQ-009 Port load, input, 1, SHALL be a one-cycle strobe requesting a date preset from set_*.
REQ-010 Ports set_day [4:0], set_month [3:0] and set_year [YEAR_W-1:0], inputs, SHALL carry the preset value.
REQ-011 Ports day [4:0], month [3:0] and year [YEAR_W-1:0], outputs, SHALL be the registered current date, 1-based, binary.
REQ-012 Ports month_carry, year_carry and load_err, outputs, 1 bit each, SHALL be registered one-cycle pulses.

Function
REQ-013 The day count of the current month SHALL be 31 for months 1,3,5,7,8,10,12 and 30 for months 4,6,9,11.
REQ-014 February SHALL have 29 days when (y%4==0 and y%100!=0) or y%400==0, else 28.
REQ-015 Leap evaluation SHALL use the full Gregorian year value held in year; no offset encoding.
REQ-016 Priority at a rising edge with en=1 SHALL be load first, then day_tick; when both are high, day_tick SHALL be ignored.
REQ-017 A valid load SHALL make day/month/year equal set_* after that edge; no carry pulses.
REQ-018 A load SHALL be valid only if set_month is 1..12, set_year is YEAR_MIN..YEAR_MAX, and set_day is 1..days(set_month, set_year).
REQ-019 An invalid load SHALL leave the date unchanged and assert load_err for exactly the next cycle.
REQ-020 day_tick with day < days(month, year) SHALL increment day only.
REQ-021 day_tick on the last day of months 1..11 SHALL set day=1, increment month, and pulse month_carry.
REQ-022 day_tick on 31 Dec with year < YEAR_MAX SHALL set 1 Jan of year+1 and pulse both month_carry and year_carry in the same cycle.
REQ-023 day_tick on 31 Dec YEAR_MAX with WRAP=1 SHALL set 1 Jan YEAR_MIN and pulse both carries.
REQ-024 day_tick on 31 Dec YEAR_MAX with WRAP=0 SHALL hold the date and pulse no carry.
REQ-025 Pulses SHALL be high only for the cycle after the causing edge and low otherwise; back-to-back ticks SHALL each be honoured, with no missed days.
REQ-026 With en=0, day_tick and load SHALL be ignored, the date SHALL hold, and all pulses SHALL be 0.
REQ-027 The date SHALL never hold an illegal value: day 0, day > days(month, year), month 0 or > 12, or year outside the legal range.

Reset
REQ-028 rst_n=0 SHALL immediately and asynchronously force day=1, month=1, year=YEAR_MIN, and month_carry=year_carry=load_err=0.
REQ-029 Reset SHALL override load and tick; an operation in flight SHALL be discarded.
REQ-030 After rst_n deasserts, the first edge with en=1 SHALL operate normally.

Verification
REQ-031 Reset: assert rst_n=0 mid-count -> outputs 1/1/2000 at once without a clock edge, all pulses 0.
REQ-032 Leap: load 28/2/2024, tick -> 29/2/2024; tick -> 1/3/2024 with month_carry=1 for one cycle. Load 28/2/2100, tick -> 1/3/2100. Load 28/2/2000, tick -> 29/2/2000.
REQ-033 Year rollover: load 31/12/2023, tick -> 1/1/2024 with month_carry=year_carry=1 for one cycle, then both 0.
REQ-034 Invalid load: from 5/6/2024, load 31/4/2024 -> load_err=1 for one cycle, date stays 5/6/2024. Repeat for 29/2/2023, month 13 and year 1999: same result.
REQ-035 Priority and enable: load 10/10/2030 with day_tick=1 -> 10/10/2030. en=0 with tick and load -> date held, pulses 0.
REQ-036 Range end: WRAP=1, 31/12/2399 tick -> 1/1/2000 with both carries. WRAP=0, same stimulus -> 31/12/2399 held, no carries.
